// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : UART transmit FIFO with holding-register mode, status flags,
//            sticky overflow and level-triggered TX interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          fifo_en,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic [2:0]    tx_ifls,
    input  logic          tx_busy,
    output logic [7:0]    fifo_data,
    output logic          fifo_data_valid,
    input  logic          fifo_data_taken,
    output logic          tx_full,
    output logic          tx_empty,
    output logic          uart_busy,
    output logic [AW:0]   tx_level,
    output logic          tx_int,
    output logic          overflow
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_ONE   = (AW+1)'(1);
    localparam logic [AW:0] C_THR0  = (AW+1)'(DEPTH / 8);
    localparam logic [AW:0] C_THR1  = (AW+1)'(DEPTH / 4);
    localparam logic [AW:0] C_THR2  = (AW+1)'(DEPTH / 2);
    localparam logic [AW:0] C_THR3  = (AW+1)'((DEPTH * 3) / 4);
    localparam logic [AW:0] C_THR4  = (AW+1)'((DEPTH * 7) / 8);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;

    logic [AW:0]   w_cap;
    logic [AW:0]   w_thr;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_cap   = fifo_en ? C_DEPTH : C_ONE;
    assign w_full  = (count_q >= w_cap);
    assign w_empty = (count_q == '0);

    // Acceptance uses the count at the start of the cycle, so a same-cycle pop
    // never makes room for a write into a full FIFO.
    assign w_push  = wr_en && !w_full && !flush;
    assign w_pop   = fifo_data_taken && !w_empty && !flush;

    always_comb begin
        case (tx_ifls)
            3'd0:    w_thr = C_THR0;
            3'd1:    w_thr = C_THR1;
            3'd2:    w_thr = C_THR2;
            3'd3:    w_thr = C_THR3;
            3'd4:    w_thr = C_THR4;
            default: w_thr = C_THR2;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (wr_en && w_full) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is deliberately not reset; valid gating hides stale contents.
    always_ff @(posedge CLK) begin
        if (w_push && !RST) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign fifo_data       = mem_q[rd_ptr_q];
    assign fifo_data_valid = !w_empty;
    assign tx_full         = w_full;
    assign tx_empty        = w_empty;
    assign uart_busy       = tx_busy || !w_empty;
    assign tx_level        = count_q;
    assign tx_int          = fifo_en ? (count_q <= w_thr) : w_empty;
    assign overflow        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Scoreboard bench for uart_tx_fifo; stimulus queues expected bytes,
//            a negedge monitor compares the head byte whenever valid is high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          fifo_en;
    logic          flush;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic [2:0]    tx_ifls;
    logic          tx_busy;
    logic [7:0]    fifo_data;
    logic          fifo_data_valid;
    logic          fifo_data_taken;
    logic          tx_full;
    logic          tx_empty;
    logic          uart_busy;
    logic [AW:0]   tx_level;
    logic          tx_int;
    logic          overflow;

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .fifo_en(fifo_en), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .tx_ifls(tx_ifls), .tx_busy(tx_busy),
        .fifo_data(fifo_data), .fifo_data_valid(fifo_data_valid),
        .fifo_data_taken(fifo_data_taken), .tx_full(tx_full), .tx_empty(tx_empty),
        .uart_busy(uart_busy), .tx_level(tx_level), .tx_int(tx_int),
        .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         m_cnt  = 0;
    bit         m_ovf  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int thr_of(input int ifls);
        case (ifls)
            0: return 2;
            1: return 4;
            2: return 8;
            3: return 12;
            4: return 14;
            default: return 8;
        endcase
    endfunction

    // Head-of-queue monitor: data must match the oldest outstanding byte every
    // cycle valid is high, and a taken pulse retires it.
    always @(negedge CLK) begin
        if (RST !== 1'b1 && flush !== 1'b1 && fifo_data_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL head_unexpected actual=%0h required=none", fifo_data);
            end else begin
                if (fifo_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL head_data actual=%0h required=%0h", fifo_data, exp_q[0]);
                end
                if (fifo_data_taken === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input bit wr, input logic [7:0] d, input bit tk);
        int cap;
        bit acc;
        bit pp;
        cap = fifo_en ? DEPTH : 1;
        wr_en           = wr;
        wr_data         = d;
        fifo_data_taken = tk;
        acc = wr && (m_cnt < cap);
        pp  = tk && (m_cnt > 0);
        if (acc) exp_q.push_back(d);
        if (wr && !acc) m_ovf = 1'b1;
        m_cnt = m_cnt + int'(acc) - int'(pp);
        @(posedge CLK); #1;
        wr_en           = 1'b0;
        fifo_data_taken = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        m_cnt = 0;
        m_ovf = 1'b0;
        exp_q.delete();
    endtask

    task automatic status(input string tag);
        int cap;
        cap = fifo_en ? DEPTH : 1;
        chk({tag, "_level"}, 32'(tx_level), 32'(m_cnt));
        chk({tag, "_empty"}, 32'(tx_empty), 32'(m_cnt == 0));
        chk({tag, "_full"},  32'(tx_full),  32'(m_cnt >= cap));
        chk({tag, "_ovf"},   32'(overflow), 32'(m_ovf));
        chk({tag, "_int"},   32'(tx_int),
            32'(fifo_en ? (m_cnt <= thr_of(int'(tx_ifls))) : (m_cnt == 0)));
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && m_cnt > 0; k++) step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ord [4];
        bit         exp_int [8];
        ord = '{8'hAA, 8'h55, 8'h80, 8'h02};
        exp_int = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        RST = 1'b1; fifo_en = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        tx_ifls = 3'd2; tx_busy = 1'b0; fifo_data_taken = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        // Reset state
        chk("rst_valid", 32'(fifo_data_valid), 32'd0);
        chk("rst_empty", 32'(tx_empty), 32'd1);
        chk("rst_full",  32'(tx_full), 32'd0);
        chk("rst_level", 32'(tx_level), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        chk("rst_int",   32'(tx_int), 32'd1);
        chk("rst_busy",  32'(uart_busy), 32'd0);

        // Taken while empty is ignored
        step(1'b0, 8'h00, 1'b1);
        status("empty_taken");

        // Ordering, with an idle cycle before each pulse to exercise stability
        foreach (ord[i]) step(1'b1, ord[i], 1'b0);
        chk("ord_level", 32'(tx_level), 32'd4);
        chk("ord_busy",  32'(uart_busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b0);
            step(1'b0, 8'h00, 1'b1);
        end
        chk("ord_empty", 32'(tx_empty), 32'd1);
        chk("ord_sb",    32'(exp_q.size()), 32'd0);

        // Fill and overflow
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        chk("fill_full",  32'(tx_full), 32'd1);
        chk("fill_level", 32'(tx_level), 32'd16);
        chk("fill_ovf0",  32'(overflow), 32'd0);
        chk("fill_int",   32'(tx_int), 32'd0);
        step(1'b1, 8'h10, 1'b0);
        chk("fill_ovf1",  32'(overflow), 32'd1);
        chk("fill_lvl17", 32'(tx_level), 32'd16);

        // Full with simultaneous push and pop: write still dropped
        step(1'b1, 8'h77, 1'b1);
        chk("fullpp_level", 32'(tx_level), 32'd15);
        chk("fullpp_ovf",   32'(overflow), 32'd1);
        chk("fullpp_full",  32'(tx_full), 32'd0);
        drain();
        status("fill_drained");
        do_flush();
        status("flush");

        // Interrupt level select at level 12
        for (int i = 0; i < 12; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        for (int s = 0; s < 8; s++) begin
            tx_ifls = 3'(s);
            #1 chk($sformatf("ifls%0d_int", s), 32'(tx_int), 32'(exp_int[s]));
        end
        tx_ifls = 3'd2;
        do_flush();

        // Wrap and interrupt, threshold 8
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(i * 7 + 3), (i % 2 == 1) || (m_cnt >= 10));
            chk("wrap_int", 32'(tx_int), 32'(m_cnt <= 8));
            chk("wrap_lvl", 32'(tx_level), 32'(m_cnt));
        end
        drain();
        status("wrap_drained");

        // Holding-register mode
        fifo_en = 1'b0;
        step(1'b1, 8'h11, 1'b0);
        status("hold1");
        chk("hold1_full", 32'(tx_full), 32'd1);
        step(1'b1, 8'h22, 1'b0);
        chk("hold2_ovf",   32'(overflow), 32'd1);
        chk("hold2_level", 32'(tx_level), 32'd1);
        step(1'b0, 8'h00, 1'b0);

        // Reset mid-operation with transmitter busy
        tx_busy = 1'b1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        m_cnt = 0; m_ovf = 1'b0; exp_q.delete();
        chk("midrst_valid", 32'(fifo_data_valid), 32'd0);
        chk("midrst_busy",  32'(uart_busy), 32'd1);
        chk("midrst_ovf",   32'(overflow), 32'd0);
        tx_busy = 1'b0;
        #1 chk("midrst_idle", 32'(uart_busy), 32'd0);

        @(posedge CLK); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side FIFO that produces bytes for the UART transmitter's fifo_data / fifo_data_valid / fifo_data_taken handshake.
- The processor-facing register block writes bytes in through a single write strobe.
- The block supplies the status flags for the UARTFR register (TXFF, TXFE, BUSY) and the level-triggered TX interrupt.
- FIFO mode is selectable: full depth, or a one-entry holding register when FIFOs are disabled.

Parameters:
DEPTH, 16, number of entries; power of two, at least 8
AW, 4, address width, equal to log2(DEPTH)

Ports:
CLK  input  1  UART clock
RST  input  1  synchronous, active-high reset
fifo_en  input  1  1 = FIFO mode with DEPTH entries; 0 = one-entry holding register
flush  input  1  synchronous clear of contents and overflow flag
wr_en  input  1  one-cycle write strobe from the register block
wr_data  input  8  byte to enqueue
tx_ifls  input  3  interrupt level select: 0 = 1/8, 1 = 1/4, 2 = 1/2, 3 = 3/4, 4 = 7/8 of DEPTH; 5-7 treated as 2
tx_busy  input  1  tx_fifo_busy from the transmitter
fifo_data  output  8  head-of-queue byte
fifo_data_valid  output  1  head byte is valid
fifo_data_taken  input  1  one-cycle pulse from the transmitter: head byte has been latched
tx_full  output  1  TXFF
tx_empty  output  1  TXFE
uart_busy  output  1  BUSY = tx_busy OR (not tx_empty)
tx_level  output  AW+1  current occupancy count
tx_int  output  1  TX interrupt (level-sensitive)
overflow  output  1  sticky flag: a write was dropped

Behaviour:
- Storage is a DEPTH x 8 register array with rd_ptr and wr_ptr (AW bits, natural wrap from DEPTH-1 to 0) and a count register (AW+1 bits).
- Capacity: cap = DEPTH when fifo_en = 1, otherwise 1.
- Reset (RST high at a CLK edge): rd_ptr = wr_ptr = count = 0 and overflow = 0. Resulting output values:
  - fifo_data_valid = 0, tx_empty = 1, tx_full = 0, tx_level = 0.
  - tx_int = 1 (empty is at or below any threshold).
  - uart_busy = tx_busy.
  - fifo_data = mem[0] with don't-care contents; the array is not cleared.
- RST has priority over every other input. Reset in the middle of a transfer discards all contents immediately.
- flush: same effect as RST on pointers, count and overflow, one cycle. Any push or pop in that cycle is ignored.
- Push: occurs when wr_en = 1 and count < cap. Effect: mem[wr_ptr] <= wr_data; wr_ptr increments.
- Dropped write: wr_en = 1 with count >= cap. The write is discarded and overflow <= 1. The flag clears only on RST or flush.
- Push acceptance is decided on count at the start of the cycle. When the FIFO is full, a pop in the same cycle does NOT make room: the write is still dropped.
- Pop: occurs when fifo_data_taken = 1 and count > 0. Effect: rd_ptr increments.
- fifo_data_taken while empty is ignored: no pointer movement, no error.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Output timing:
  - fifo_data = mem[rd_ptr] (combinational read).
  - fifo_data_valid = (count != 0).
  - Latency from a write into an empty FIFO to valid = 1 is one cycle.
  - After a pop, valid and data reflect the new head on the next cycle.
  - fifo_data is stable while valid = 1 and no pop occurs.
- Handshake rule: a taken pulse longer than one cycle pops once per cycle. The transmitter guarantees single-cycle pulses.
- tx_full = (count >= cap). tx_empty = (count == 0).
- Changing fifo_en with data present does not discard data. The FIFO keeps draining normally, and tx_full reflects the new cap immediately.
- tx_int = (count <= thr), where thr = DEPTH*N/8 with N = 1, 2, 4, 6, 7 for tx_ifls 0-4.
  - For DEPTH = 16: thr = 2, 4, 8, 12, 14.
  - When fifo_en = 0: tx_int = tx_empty.
- All status outputs are combinational from the registered state.

Test Plan:
- Reset then idle: RST high for 3 cycles, then low → fifo_data_valid = 0, tx_empty = 1, tx_level = 0, overflow = 0, tx_int = 1.
- Ordering: write 8'hAA, 8'h55, 8'h80, 8'h02 on consecutive cycles, then pulse taken once each time valid = 1 → fifo_data presents AA, 55, 80, 02 in order, each stable until its pulse, and tx_empty = 1 at the end.
- Fill and overflow: with fifo_en = 1, write 17 bytes 0x00..0x10 → tx_full = 1 after the 16th write, the 17th is dropped, overflow = 1. Draining yields 0x00..0x0F.
- Full with simultaneous push and pop: with the FIFO full, assert wr_en (0x77) and taken in the same cycle → tx_level 16 → 15, 0x77 is not stored, overflow = 1.
- Wrap and interrupt: run 40 interleaved writes and pops with tx_ifls = 2 → data order is preserved across the pointer wrap, and tx_int is high exactly when tx_level <= 8.
- Holding-register mode and reset mid-operation: fifo_en = 0, write 0x11 then 0x22 → tx_full = 1, 0x22 is dropped. With tx_busy = 1 and one byte queued, assert RST → valid = 0 on the next cycle and uart_busy follows tx_busy.
